// File: rtl/focal_scan_scheduler_if.sv
// Host and delay-controller bundle for the focal scan scheduler.
// The scheduler side is the slave; the host/controller side is the master.
interface focal_scan_scheduler_if #(
  parameter int NUM_X = 8,
  parameter int NUM_Z = 16
);
  localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1;
  localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;

  logic          frame_start;
  logic          frame_abort;
  logic          dc_ready;
  logic          dc_reset;
  logic          dc_start;
  logic [15:0]   x_f;
  logic [15:0]   z_f;
  logic          acq_valid;
  logic          point_done;
  logic          line_done;
  logic          frame_done;
  logic          busy;
  logic          error;
  logic [XW-1:0] x_idx;
  logic [ZW-1:0] z_idx;

  modport master (
    output frame_start,
    output frame_abort,
    output dc_ready,
    input  dc_reset,
    input  dc_start,
    input  x_f,
    input  z_f,
    input  acq_valid,
    input  point_done,
    input  line_done,
    input  frame_done,
    input  busy,
    input  error,
    input  x_idx,
    input  z_idx
  );

  modport slave (
    input  frame_start,
    input  frame_abort,
    input  dc_ready,
    output dc_reset,
    output dc_start,
    output x_f,
    output z_f,
    output acq_valid,
    output point_done,
    output line_done,
    output frame_done,
    output busy,
    output error,
    output x_idx,
    output z_idx
  );
endinterface

// File: rtl/focal_scan_scheduler.sv
// Steps the delay controller over a line-outer, depth-inner focal grid,
// opening a fixed acquisition window per point and flagging ready timeouts.
module focal_scan_scheduler #(
  parameter logic [15:0] X_START = 16'd0,
  parameter logic [15:0] X_STEP  = 16'd4,
  parameter int          NUM_X   = 8,
  parameter logic [15:0] Z_START = 16'd64,
  parameter logic [15:0] Z_STEP  = 16'd8,
  parameter int          NUM_Z   = 16,
  parameter int          DWELL   = 32,
  parameter int          TIMEOUT = 1024
) (
  input  logic clk,
  input  logic reset,
  focal_scan_scheduler_if.slave bus
);
  localparam int XW = (NUM_X > 1) ? $clog2(NUM_X) : 1;
  localparam int ZW = (NUM_Z > 1) ? $clog2(NUM_Z) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int DW = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int CW = (TW > DW) ? TW : DW;

  localparam logic [XW-1:0] X_LAST = XW'(NUM_X - 1);
  localparam logic [ZW-1:0] Z_LAST = ZW'(NUM_Z - 1);
  localparam logic [CW-1:0] T_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] D_LAST = CW'(DWELL - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_LAUNCH,
    S_WAIT,
    S_DWELL,
    S_ADV
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [15:0]   x_f_q, x_f_d;
  logic [15:0]   z_f_q, z_f_d;
  logic [XW-1:0] x_idx_q, x_idx_d;
  logic [ZW-1:0] z_idx_q, z_idx_d;
  logic          error_q, error_d;

  logic busy_q, dc_reset_q, dc_start_q;
  logic acq_q, pd_q, ld_q, fd_q;
  logic pd_d, ld_d, fd_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    x_f_d   = x_f_q;
    z_f_d   = z_f_q;
    x_idx_d = x_idx_q;
    z_idx_d = z_idx_q;
    error_d = error_q;
    if (state_q != S_IDLE && bus.frame_abort) begin
      state_d = S_IDLE;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.frame_start && !bus.frame_abort) begin
            x_idx_d = '0;
            z_idx_d = '0;
            x_f_d   = X_START;
            z_f_d   = Z_START;
            error_d = 1'b0;
            state_d = S_CLEAR;
          end
        end
        S_CLEAR: state_d = S_LAUNCH;
        S_LAUNCH: begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          // ready on the last permitted cycle still beats the timeout
          if (bus.dc_ready) begin
            cnt_d   = '0;
            state_d = S_DWELL;
          end else if (cnt_q == T_LAST) begin
            error_d = 1'b1;
            state_d = S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_DWELL: begin
          if (cnt_q == D_LAST) begin
            state_d = S_ADV;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_ADV: begin
          if (z_idx_q != Z_LAST) begin
            z_idx_d = z_idx_q + 1'b1;
            z_f_d   = z_f_q + Z_STEP;
            state_d = S_CLEAR;
          end else if (x_idx_q != X_LAST) begin
            z_idx_d = '0;
            z_f_d   = Z_START;
            x_idx_d = x_idx_q + 1'b1;
            x_f_d   = x_f_q + X_STEP;
            state_d = S_CLEAR;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // indices hold through DWELL, so they still name the finishing point
  assign pd_d = (state_d == S_ADV);
  assign ld_d = pd_d && (z_idx_q == Z_LAST);
  assign fd_d = ld_d && (x_idx_q == X_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      x_f_q      <= '0;
      z_f_q      <= '0;
      x_idx_q    <= '0;
      z_idx_q    <= '0;
      error_q    <= 1'b0;
      busy_q     <= 1'b0;
      dc_reset_q <= 1'b0;
      dc_start_q <= 1'b0;
      acq_q      <= 1'b0;
      pd_q       <= 1'b0;
      ld_q       <= 1'b0;
      fd_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      x_f_q      <= x_f_d;
      z_f_q      <= z_f_d;
      x_idx_q    <= x_idx_d;
      z_idx_q    <= z_idx_d;
      error_q    <= error_d;
      busy_q     <= (state_d != S_IDLE);
      dc_reset_q <= (state_d == S_CLEAR);
      dc_start_q <= (state_d == S_LAUNCH);
      acq_q      <= (state_d == S_DWELL);
      pd_q       <= pd_d;
      ld_q       <= ld_d;
      fd_q       <= fd_d;
    end
  end

  assign bus.dc_reset   = dc_reset_q;
  assign bus.dc_start   = dc_start_q;
  assign bus.x_f        = x_f_q;
  assign bus.z_f        = z_f_q;
  assign bus.acq_valid  = acq_q;
  assign bus.point_done = pd_q;
  assign bus.line_done  = ld_q;
  assign bus.frame_done = fd_q;
  assign bus.busy       = busy_q;
  assign bus.error      = error_q;
  assign bus.x_idx      = x_idx_q;
  assign bus.z_idx      = z_idx_q;
endmodule

// File: tb/tb_focal_scan_scheduler.sv
// Bench for focal_scan_scheduler: two instances (plain and wrapping depth)
// checked every cycle against a point-timeline reference model.
module tb_focal_scan_scheduler;
  localparam int NX = 2;
  localparam int NZ = 3;
  localparam int DW = 4;
  localparam logic [15:0] XS  = 16'd0;
  localparam logic [15:0] XST = 16'd4;
  localparam logic [15:0] ZST = 16'd8;
  localparam logic [15:0] ZS0 = 16'd64;
  localparam logic [15:0] ZS1 = 16'hFFF8;
  localparam int TO0 = 32;
  localparam int TO1 = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fs = 1'b0;
  logic fa = 1'b0;
  logic [1:0] rdy = 2'b00;
  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  focal_scan_scheduler_if #(.NUM_X(NX), .NUM_Z(NZ)) b0 ();
  focal_scan_scheduler_if #(.NUM_X(NX), .NUM_Z(NZ)) b1 ();

  assign b0.frame_start = fs;
  assign b0.frame_abort = fa;
  assign b0.dc_ready    = rdy[0];
  assign b1.frame_start = fs;
  assign b1.frame_abort = fa;
  assign b1.dc_ready    = rdy[1];

  focal_scan_scheduler #(
    .X_START(XS), .X_STEP(XST), .NUM_X(NX),
    .Z_START(ZS0), .Z_STEP(ZST), .NUM_Z(NZ),
    .DWELL(DW), .TIMEOUT(TO0)
  ) u_dut0 (
    .clk(clk), .reset(rst_n), .bus(b0.slave)
  );

  focal_scan_scheduler #(
    .X_START(XS), .X_STEP(XST), .NUM_X(NX),
    .Z_START(ZS1), .Z_STEP(ZST), .NUM_Z(NZ),
    .DWELL(DW), .TIMEOUT(TO1)
  ) u_dut1 (
    .clk(clk), .reset(rst_n), .bus(b1.slave)
  );

  // {busy, dc_reset, dc_start, acq_valid, point_done, line_done, frame_done, error}
  logic [1:0][7:0]  ctl;
  logic [1:0][15:0] ox, oz;
  logic [1:0][1:0]  oxi, ozi;
  assign ctl[0] = {b0.busy, b0.dc_reset, b0.dc_start, b0.acq_valid,
                   b0.point_done, b0.line_done, b0.frame_done, b0.error};
  assign ctl[1] = {b1.busy, b1.dc_reset, b1.dc_start, b1.acq_valid,
                   b1.point_done, b1.line_done, b1.frame_done, b1.error};
  assign ox[0] = b0.x_f;
  assign oz[0] = b0.z_f;
  assign ox[1] = b1.x_f;
  assign oz[1] = b1.z_f;
  assign oxi[0] = {1'b0, b0.x_idx};
  assign ozi[0] = b0.z_idx;
  assign oxi[1] = {1'b0, b1.x_idx};
  assign ozi[1] = b1.z_idx;

  // reference: frame = list of points, each point a timeline of offsets
  bit act[2];
  bit err[2];
  int tp[2];
  int pt[2];
  int lat[2];
  logic [15:0] mx[2];
  logic [15:0] mz[2];
  bit use_fix = 1'b1;
  int fixl[2];
  int dcc[2];
  bit arm[2];
  int pd_cnt[2];
  int ld_cnt[2];
  int fd_cnt[2];
  int acq_cnt[2];
  bit logging = 1'b0;
  logic [15:0] zlog1[$];
  logic [31:0] xzlog0[$];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int tmo(int i);
    return (i != 0) ? TO1 : TO0;
  endfunction

  function automatic logic [15:0] zst(int i);
    return (i != 0) ? ZS1 : ZS0;
  endfunction

  function automatic bit timed(int i);
    return !(lat[i] != 0 && lat[i] <= tmo(i));
  endfunction

  function automatic int wcyc(int i);
    return timed(i) ? tmo(i) : lat[i];
  endfunction

  function automatic logic [7:0] exp_ctl(int i);
    bit pd, acq;
    int w;
    w   = wcyc(i);
    acq = act[i] && !timed(i) && tp[i] >= 2 + w && tp[i] <= 1 + w + DW;
    pd  = act[i] && !timed(i) && tp[i] == 2 + w + DW;
    return {act[i], act[i] && tp[i] == 0, act[i] && tp[i] == 1, acq, pd,
            pd && (pt[i] % NZ == NZ - 1), pd && (pt[i] == NX * NZ - 1),
            err[i]};
  endfunction

  task automatic new_point(int i);
    tp[i] = 0;
    mx[i] = XS + XST * 16'(pt[i] / NZ);
    mz[i] = zst(i) + ZST * 16'(pt[i] % NZ);
    if (use_fix) lat[i] = fixl[i];
    else if ($urandom_range(0, 19) == 0) lat[i] = 0;
    else lat[i] = int'($urandom_range(1, 22));
  endtask

  task automatic model_reset(int i);
    act[i] = 1'b0;
    err[i] = 1'b0;
    tp[i]  = 0;
    pt[i]  = 0;
    lat[i] = 1;
    mx[i]  = '0;
    mz[i]  = '0;
  endtask

  task automatic model_step(int i);
    if (!rst_n) begin
      model_reset(i);
    end else if (!act[i]) begin
      if (fs && !fa) begin
        act[i] = 1'b1;
        err[i] = 1'b0;
        pt[i]  = 0;
        new_point(i);
      end
    end else if (fa) begin
      act[i] = 1'b0;
    end else begin
      tp[i]++;
      if (timed(i) && tp[i] == 2 + tmo(i)) begin
        act[i] = 1'b0;
        err[i] = 1'b1;
      end else if (!timed(i) && tp[i] == 3 + wcyc(i) + DW) begin
        if (pt[i] == NX * NZ - 1) begin
          act[i] = 1'b0;
        end else begin
          pt[i]++;
          new_point(i);
        end
      end
    end
  endtask

  task automatic compare(int i);
    check($sformatf("ctl%0d", i), 32'(ctl[i]), 32'(exp_ctl(i)));
    check($sformatf("x_f%0d", i), 32'(ox[i]), 32'(mx[i]));
    check($sformatf("z_f%0d", i), 32'(oz[i]), 32'(mz[i]));
    if (act[i]) begin
      check($sformatf("x_idx%0d", i), 32'(oxi[i]), 32'(pt[i] / NZ));
      check($sformatf("z_idx%0d", i), 32'(ozi[i]), 32'(pt[i] % NZ));
    end
  endtask

  // delay-controller stand-in: ready lat cycles after dc_start, cleared by dc_reset
  task automatic dc_model(int i);
    if (!rst_n) begin
      rdy[i] = 1'b0;
      arm[i] = 1'b0;
    end else if (ctl[i][6]) begin
      rdy[i] = 1'b0;
      arm[i] = 1'b0;
    end else if (ctl[i][5]) begin
      arm[i] = 1'b1;
      dcc[i] = 0;
    end else if (arm[i]) begin
      dcc[i]++;
      if (lat[i] != 0 && dcc[i] == lat[i]) rdy[i] = 1'b1;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      compare(i);
      if (ctl[i][4]) acq_cnt[i]++;
      if (ctl[i][3]) pd_cnt[i]++;
      if (ctl[i][2]) ld_cnt[i]++;
      if (ctl[i][1]) fd_cnt[i]++;
      dc_model(i);
    end
    if (logging && ctl[1][3]) zlog1.push_back(oz[1]);
    if (logging && ctl[0][3]) xzlog0.push_back({ox[0], oz[0]});
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 2; i++) begin
      pd_cnt[i]  = 0;
      ld_cnt[i]  = 0;
      fd_cnt[i]  = 0;
      acq_cnt[i] = 0;
    end
  endtask

  task automatic start_frame();
    fs = 1'b1;
    cycle();
    fs = 1'b0;
  endtask

  task automatic run_idle(int limit);
    int n;
    n = 0;
    while ((act[0] || act[1]) && n < limit) begin
      cycle();
      n++;
    end
    cycle();
    check("idle_end", 32'({ctl[0][7], ctl[1][7]}), 32'd0);
  endtask

  task automatic run_until_tp0(int target, int limit);
    int n;
    n = 0;
    while (tp[0] != target && n < limit) begin
      cycle();
      n++;
    end
    check("reach_tp", 32'(tp[0]), 32'(target));
  endtask

  localparam logic [15:0] ZW_EXP [6] = '{16'hFFF8, 16'h0000, 16'h0008,
                                         16'hFFF8, 16'h0000, 16'h0008};
  localparam logic [31:0] XZ_EXP [6] = '{{16'd0, 16'd64}, {16'd0, 16'd72},
                                         {16'd0, 16'd80}, {16'd4, 16'd64},
                                         {16'd4, 16'd72}, {16'd4, 16'd80}};

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      arm[i] = 1'b0;
      dcc[i] = 0;
    end
    clr_counts();
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // nominal frame, ready 20 cycles after dc_start (5 on the wrap instance)
    fixl[0] = 20;
    fixl[1] = 5;
    clr_counts();
    logging = 1'b1;
    start_frame();
    run_idle(600);
    logging = 1'b0;
    check("pd_cnt0", 32'(pd_cnt[0]), 32'd6);
    check("ld_cnt0", 32'(ld_cnt[0]), 32'd2);
    check("fd_cnt0", 32'(fd_cnt[0]), 32'd1);
    check("acq_cnt0", 32'(acq_cnt[0]), 32'd24);
    check("pd_cnt1", 32'(pd_cnt[1]), 32'd6);
    check("xz_len", 32'(xzlog0.size()), 32'd6);
    check("zw_len", 32'(zlog1.size()), 32'd6);
    for (int k = 0; k < 6 && k < xzlog0.size(); k++)
      check($sformatf("xz_seq%0d", k), xzlog0[k], XZ_EXP[k]);
    for (int k = 0; k < 6 && k < zlog1.size(); k++)
      check($sformatf("zwrap%0d", k), 32'(zlog1[k]), 32'(ZW_EXP[k]));

    // ready never arrives: both instances time out
    fixl[0] = 0;
    fixl[1] = 0;
    clr_counts();
    start_frame();
    run_idle(200);
    check("tmo_err", 32'({ctl[0][0], ctl[1][0]}), 32'd3);
    check("tmo_pd", 32'(pd_cnt[0] + pd_cnt[1]), 32'd0);
    fixl[0] = 3;
    fixl[1] = 7;
    clr_counts();
    start_frame();
    check("err_clr", 32'({ctl[0][0], ctl[1][0]}), 32'd0);
    run_idle(400);
    check("re_pd0", 32'(pd_cnt[0]), 32'd6);

    // abort in the middle of point 2's acquisition window
    fixl[0] = 6;
    fixl[1] = 2;
    clr_counts();
    start_frame();
    while (pt[0] != 1 && act[0]) cycle();
    run_until_tp0(2 + 6 + 1, 100);
    fa = 1'b1;
    cycle();
    fa = 1'b0;
    check("abort_acq", 32'(ctl[0][4]), 32'd0);
    check("abort_busy", 32'(ctl[0][7]), 32'd0);
    check("abort_pd", 32'(pd_cnt[0]), 32'd1);
    start_frame();
    check("restart_x", 32'(ox[0]), 32'd0);
    check("restart_z", 32'(oz[0]), 32'd64);
    run_idle(400);

    // start+abort together in idle, then start pulsed during wait
    fs = 1'b1;
    fa = 1'b1;
    cycle();
    fs = 1'b0;
    fa = 1'b0;
    check("sa_idle", 32'({ctl[0][7], ctl[1][7]}), 32'd0);
    fixl[0] = 12;
    fixl[1] = 12;
    clr_counts();
    start_frame();
    run_until_tp0(5, 40);
    start_frame();
    run_idle(600);
    check("ign_pd0", 32'(pd_cnt[0]), 32'd6);
    check("ign_fd1", 32'(fd_cnt[1]), 32'd1);

    // asynchronous reset mid-wait
    fixl[0] = 20;
    fixl[1] = 20;
    start_frame();
    run_until_tp0(8, 40);
    #2;
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      check($sformatf("arst_ctl%0d", i), 32'(ctl[i]), 32'd0);
      check($sformatf("arst_xz%0d", i), {ox[i], oz[i]}, 32'd0);
      check($sformatf("arst_idx%0d", i), 32'({oxi[i], ozi[i]}), 32'd0);
      model_reset(i);
      dc_model(i);
    end
    repeat (2) cycle();
    rst_n = 1'b1;
    cycle();

    // random traffic
    use_fix = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      fs = ($urandom_range(0, 29) == 0);
      fa = ($urandom_range(0, 149) == 0);
      cycle();
    end
    fs = 1'b0;
    fa = 1'b0;
    run_idle(600);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/focal_scan_scheduler.md
# focal_scan_scheduler

Sequences the beamformer's delay controller across a rectangular grid of focal points. For each point it drives the focal coordinates, clears and launches the delay controller, and waits for delay-ready. It then opens an acquisition window of fixed length and advances to the next point. It sits between the frame-level host control and the delay controller/sample-delay datapath, and reports progress and timeout errors.

## Interface
- `X_START`, 16'd0: lateral coordinate of the first scan line.
- `X_STEP`, 16'd4: lateral increment between lines.
- `NUM_X`, 8: scan lines per frame (≥1).
- `Z_START`, 16'd64: depth of the first focal point on each line.
- `Z_STEP`, 16'd8: depth increment.
- `NUM_Z`, 16: focal points per line (≥1).
- `DWELL`, 32: acquisition-window length in cycles (≥1).
- `TIMEOUT`, 1024: maximum wait cycles for `dc_ready`.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `frame_start` in 1: pulse; begins a frame when idle.
- `frame_abort` in 1: level; returns the block to IDLE.
- `dc_ready` in 1: delay-controller ready; sticky until `dc_reset`.
- `dc_reset` out 1: synchronous active-high clear to the delay controller.
- `dc_start` out 1: one-cycle start pulse to the delay controller.
- `x_f` out 16: current lateral focal coordinate.
- `z_f` out 16: current depth focal coordinate.
- `acq_valid` out 1: high during the acquisition window.
- `point_done` out 1: one-cycle pulse per completed point.
- `line_done` out 1: one-cycle pulse per completed line.
- `frame_done` out 1: one-cycle pulse per completed frame.
- `busy` out 1: high in any state except IDLE.
- `error` out 1: sticky timeout flag.
- `x_idx` out $clog2(NUM_X): current line index.
- `z_idx` out $clog2(NUM_Z): current point index.

## Operation
- States: IDLE, CLEAR, LAUNCH, WAIT_RDY, DWELL, ADVANCE.
- IDLE: on `frame_start`=1 and `frame_abort`=0:
  - load x_idx=z_idx=0, `x_f`=X_START, `z_f`=Z_START;
  - clear `error`; go to CLEAR.
- CLEAR: `dc_reset`=1 for one cycle; go to LAUNCH.
- LAUNCH: `dc_start`=1 for one cycle; clear the wait counter; go to WAIT_RDY.
- WAIT_RDY:
  - sample `dc_ready` only in this state;
  - `dc_ready`=1 → DWELL, with the dwell counter cleared;
  - otherwise increment the wait counter;
  - when the counter reaches TIMEOUT-1 with no ready: set `error`, go to IDLE, no done pulses.
- DWELL: `acq_valid`=1; after DWELL cycles go to ADVANCE.
- ADVANCE: pulse `point_done`, then branch:
  - z_idx<NUM_Z-1: z_idx+1, `z_f`+=Z_STEP, go to CLEAR.
  - else z_idx=0, `z_f`=Z_START, pulse `line_done`:
    - x_idx<NUM_X-1: x_idx+1, `x_f`+=X_STEP, go to CLEAR.
    - else pulse `frame_done`, go to IDLE; `x_f`/`z_f` keep their last values.
- Scan order: depth-inner, line-outer.
- Coordinate arithmetic is incremental, unsigned 16-bit, and wraps modulo 2^16. No saturation.
- `x_f`/`z_f` change only on the ADVANCE→CLEAR transition, the IDLE load, and reset. They are stable from CLEAR through ADVANCE.
- `frame_start` while busy is ignored.
- `frame_abort`=1 in any busy state → IDLE next cycle:
  - `acq_valid`, `dc_start`, `dc_reset` deassert that cycle;
  - no done pulses; `error` is unchanged.
- `frame_abort` and `frame_start` together in IDLE: abort wins, frame not started.
- Reset (asynchronous, any time): state=IDLE and all outputs 0, including `x_f`, `z_f`, the indices and `error`.

## Timing
- All outputs are registered.
- From the `frame_start` cycle, `dc_reset` is high at cycle +1 and `dc_start` at +2.
- `dc_ready` first sampled at cycle L:
  - `acq_valid` high for cycles L+1 … L+DWELL;
  - `point_done` at L+DWELL+1;
  - next `dc_reset` at L+DWELL+2.
- Per-point overhead beyond the ready wait and DWELL: 3 cycles (CLEAR, LAUNCH, ADVANCE).
- `line_done` and `frame_done` coincide with the `point_done` of the final point.
- `busy` drops the cycle after `frame_done`.
- Timeout: `error` and `busy`=0 are visible TIMEOUT+1 cycles after `dc_start`.

## Test plan
- NUM_X=2, NUM_Z=3, DWELL=4, delay-controller model asserts ready 20 cycles after `dc_start` → required response:
  - 6 `point_done`, 2 `line_done`, 1 `frame_done`;
  - (x_f,z_f) sequence (0,64)(0,72)(0,80)(4,64)(4,72)(4,80);
  - each `acq_valid` window exactly 4 cycles.
- Ready model never responds, TIMEOUT=16 → `error`=1 and `busy`=0 at 17 cycles after `dc_start`, no done pulses; the next `frame_start` clears `error` and the frame completes.
- `frame_abort` asserted mid-DWELL on point 2 → next cycle `acq_valid`=0 and state IDLE, no `point_done`; `frame_start` then restarts at (0,64).
- `frame_start` pulsed during WAIT_RDY, and `frame_start`+`frame_abort` together in IDLE → both ignored; sequence and counts unchanged.
- Async reset dropped mid-WAIT_RDY → all outputs 0 immediately (no clock edge needed) and state IDLE after release.
- Wrap check: Z_START=16'hFFF8, Z_STEP=8, NUM_Z=3 → `z_f` sequence FFF8, 0000, 0008.
